// File: rtl/cgol_board_memory.sv
// cgol_board_memory: double-buffered 8x8 Life board with display port and LFSR random fill
module cgol_board_memory #(
    parameter logic [63:0] INIT_PATTERN = 64'h0000_0000_0038_0000,
    parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  memory_operation,
    input  logic [5:0]  memory_operation_address,
    input  logic        i_data,
    output logic        o_data,
    input  logic [5:0]  i_disp_addr,
    output logic        o_disp_data,
    input  logic        i_randomize,
    output logic        o_busy,
    output logic [15:0] o_generation
);
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SWAP  = 2'b10;
    // an all-zero seed would lock the LFSR, so it is replaced by 1
    localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    typedef enum logic {IDLE, FILL} state_t;

    state_t      state_q;
    logic [63:0] cur_q, nxt_q;
    logic [7:0]  lfsr_q, lfsr_d;
    logic [5:0]  idx_q;
    logic        data_q, disp_q, busy_q;
    logic [15:0] gen_q;

    assign lfsr_d       = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign o_data       = data_q;
    assign o_disp_data  = disp_q;
    assign o_busy       = busy_q;
    assign o_generation = gen_q;

    // engine-side ops in IDLE; randomize wins and starts a 64-cycle fill of the current board
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cur_q   <= INIT_PATTERN;
            nxt_q   <= 64'd0;
            lfsr_q  <= SEED;
            idx_q   <= 6'd0;
            data_q  <= 1'b0;
            busy_q  <= 1'b0;
            gen_q   <= 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_randomize) begin
                        nxt_q   <= 64'd0;
                        cur_q   <= 64'd0;
                        gen_q   <= 16'd0;
                        idx_q   <= 6'd0;
                        busy_q  <= 1'b1;
                        state_q <= FILL;
                    end else begin
                        case (memory_operation)
                            OP_READ:  data_q <= cur_q[memory_operation_address];
                            OP_WRITE: nxt_q[memory_operation_address] <= i_data;
                            OP_SWAP: begin
                                cur_q <= nxt_q;
                                nxt_q <= 64'd0;
                                gen_q <= gen_q + 16'd1;
                            end
                            default: ;
                        endcase
                    end
                end
                FILL: begin
                    cur_q[idx_q] <= lfsr_q[0];
                    lfsr_q       <= lfsr_d;
                    idx_q        <= idx_q + 6'd1;
                    if (idx_q == 6'd63) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // display read runs every cycle regardless of opcode or fill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) disp_q <= 1'b0;
        else        disp_q <= cur_q[i_disp_addr];
    end
endmodule

// File: tb/tb_cgol_board_memory.sv
// tb_cgol_board_memory: directed self-checking bench for cgol_board_memory
module tb_cgol_board_memory;
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SWAP  = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  op = OP_NOP;
    logic [5:0]  addr = 6'd0;
    logic        wdata = 1'b0;
    logic        o_data;
    logic [5:0]  disp_addr = 6'd0;
    logic        o_disp_data;
    logic        rnd = 1'b0;
    logic        o_busy;
    logic [15:0] o_generation;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] pattern;

    cgol_board_memory dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .memory_operation         (op),
        .memory_operation_address (addr),
        .i_data                   (wdata),
        .o_data                   (o_data),
        .i_disp_addr              (disp_addr),
        .o_disp_data              (o_disp_data),
        .i_randomize              (rnd),
        .o_busy                   (o_busy),
        .o_generation             (o_generation)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [1:0] o, input logic [5:0] a, input logic d);
        op = o; addr = a; wdata = d;
        tick();
    endtask

    // expected fill pattern: cell k is bit 0 of seed 8'hA5 advanced k times
    task automatic build_pattern();
        logic [7:0] l;
        l = 8'hA5;
        for (int k = 0; k < 64; k++) begin
            pattern[k] = l[0];
            l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (o_data !== 1'b0) begin n_err++; $display("FAIL reset_o_data got %b exp 0", o_data); end
        n_cmp++; if (o_disp_data !== 1'b0) begin n_err++; $display("FAIL reset_disp got %b exp 0", o_disp_data); end
        n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", o_busy); end
        n_cmp++; if (o_generation !== 16'd0) begin n_err++; $display("FAIL reset_gen got %0d exp 0", o_generation); end
    endtask

    task automatic test_read_init();
        logic [5:0] a [4] = '{6'd19, 6'd20, 6'd21, 6'd0};
        logic       e [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            issue(OP_READ, a[i], 1'b0);
            n_cmp++; if (o_data !== e[i]) begin n_err++; $display("FAIL read_init addr %0d got %b exp %b", a[i], o_data, e[i]); end
        end
    endtask

    task automatic test_write_swap();
        issue(OP_WRITE, 6'd5, 1'b1);
        issue(OP_WRITE, 6'd5, 1'b1);
        issue(OP_READ, 6'd5, 1'b0);
        n_cmp++; if (o_data !== 1'b0) begin n_err++; $display("FAIL write_not_visible got %b exp 0", o_data); end
        issue(OP_SWAP, 6'd0, 1'b0);
        issue(OP_READ, 6'd5, 1'b0);
        n_cmp++; if (o_data !== 1'b1) begin n_err++; $display("FAIL swap_read5 got %b exp 1", o_data); end
        issue(OP_READ, 6'd20, 1'b0);
        n_cmp++; if (o_data !== 1'b0) begin n_err++; $display("FAIL swap_read20 got %b exp 0", o_data); end
        n_cmp++; if (o_generation !== 16'd1) begin n_err++; $display("FAIL swap_gen got %0d exp 1", o_generation); end
    endtask

    task automatic test_gen_wrap();
        op = OP_SWAP;
        repeat (65534) tick();
        n_cmp++; if (o_generation !== 16'hFFFF) begin n_err++; $display("FAIL gen_ffff got %h exp ffff", o_generation); end
        tick();
        n_cmp++; if (o_generation !== 16'd0) begin n_err++; $display("FAIL gen_wrap got %h exp 0000", o_generation); end
        issue(OP_READ, 6'd5, 1'b0);
        n_cmp++; if (o_data !== 1'b0) begin n_err++; $display("FAIL wrap_read5 got %b exp 0", o_data); end
        issue(OP_READ, 6'd20, 1'b0);
        n_cmp++; if (o_data !== 1'b0) begin n_err++; $display("FAIL wrap_read20 got %b exp 0", o_data); end
    endtask

    // runs one fill; when meddle is set, writes and swaps are issued while busy
    task automatic run_fill(input bit meddle, input string tag);
        logic hold;
        hold = o_data;
        op = OP_NOP;
        rnd = 1'b1;
        tick();
        rnd = 1'b0;
        n_cmp++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL %s busy_start got %b exp 1", tag, o_busy); end
        for (int i = 1; i < 64; i++) begin
            op = meddle ? ((i % 2) ? OP_WRITE : OP_SWAP) : OP_NOP;
            addr = 6'd7; wdata = 1'b1;
            tick();
            if (i == 32 || i == 63) begin
                n_cmp++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL %s busy_cycle%0d got %b exp 1", tag, i, o_busy); end
            end
        end
        op = OP_NOP;
        tick();
        n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL %s busy_end got %b exp 0", tag, o_busy); end
        n_cmp++; if (o_generation !== 16'd0) begin n_err++; $display("FAIL %s fill_gen got %0d exp 0", tag, o_generation); end
        n_cmp++; if (o_data !== hold) begin n_err++; $display("FAIL %s fill_hold got %b exp %b", tag, o_data, hold); end
    endtask

    task automatic test_fill();
        issue(OP_SWAP, 6'd0, 1'b0);
        n_cmp++; if (o_generation !== 16'd1) begin n_err++; $display("FAIL prefill_gen got %0d exp 1", o_generation); end
        run_fill(1'b0, "fill1");
    endtask

    task automatic test_disp_sweep(input string tag);
        for (int k = 0; k < 64; k++) begin
            disp_addr = 6'(k);
            issue(OP_READ, 6'(63 - k), 1'b0);
            n_cmp++; if (o_disp_data !== pattern[k]) begin n_err++; $display("FAIL %s disp cell %0d got %b exp %b", tag, k, o_disp_data, pattern[k]); end
            n_cmp++; if (o_data !== pattern[63 - k]) begin n_err++; $display("FAIL %s read cell %0d got %b exp %b", tag, 63 - k, o_data, pattern[63 - k]); end
        end
    endtask

    task automatic test_reset_mid_fill();
        op = OP_NOP;
        rnd = 1'b1;
        tick();
        rnd = 1'b0;
        repeat (29) tick();
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b exp 0", o_busy); end
        n_cmp++; if (o_data !== 1'b0) begin n_err++; $display("FAIL midrst_o_data got %b exp 0", o_data); end
        n_cmp++; if (o_generation !== 16'd0) begin n_err++; $display("FAIL midrst_gen got %0d exp 0", o_generation); end
        @(negedge clk);
        rst_n = 1'b1;
        issue(OP_READ, 6'd20, 1'b0);
        n_cmp++; if (o_data !== 1'b1) begin n_err++; $display("FAIL midrst_read20 got %b exp 1", o_data); end
        issue(OP_READ, 6'd22, 1'b0);
        n_cmp++; if (o_data !== 1'b0) begin n_err++; $display("FAIL midrst_read22 got %b exp 0", o_data); end
    endtask

    task automatic test_busy_ignored();
        run_fill(1'b1, "fill2");
        test_disp_sweep("sweep2");
        issue(OP_SWAP, 6'd0, 1'b0);
        issue(OP_READ, 6'd7, 1'b0);
        n_cmp++; if (o_data !== 1'b0) begin n_err++; $display("FAIL busy_write_ignored got %b exp 0", o_data); end
        n_cmp++; if (o_generation !== 16'd1) begin n_err++; $display("FAIL post_fill_swap_gen got %0d exp 1", o_generation); end
    endtask

    initial begin
        build_pattern();
        @(negedge clk);
        test_reset();
        test_read_init();
        test_write_swap();
        test_gen_wrap();
        test_fill();
        test_disp_sweep("sweep1");
        test_reset_mid_fill();
        test_busy_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
